// File: rtl/reduction_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reduction_arbiter_pkg
// Description : Opcodes, result-bit indices and FSM states shared by the
//               reduction arbiter and its winner picker.
// Revision    : 1.0 - initial release
// ============================================================================
package reduction_arbiter_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_NAND = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;

    // Bit positions within red_y = {and, nand, or, nor, xor, xnor}
    localparam int RB_AND  = 5;
    localparam int RB_NAND = 4;
    localparam int RB_OR   = 3;
    localparam int RB_NOR  = 2;
    localparam int RB_XOR  = 1;
    localparam int RB_XNOR = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    // Returns {err, bit}; the result bit is passed straight through so X/Z survive.
    function automatic logic [1:0] sel_result(input logic [2:0] op, input logic [5:0] y);
        logic [1:0] r;
        r = 2'b10;
        case (op)
            OP_AND:  r = {1'b0, y[RB_AND]};
            OP_NAND: r = {1'b0, y[RB_NAND]};
            OP_OR:   r = {1'b0, y[RB_OR]};
            OP_NOR:  r = {1'b0, y[RB_NOR]};
            OP_XOR:  r = {1'b0, y[RB_XOR]};
            OP_XNOR: r = {1'b0, y[RB_XNOR]};
            default: r = 2'b10;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reduction_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational one-hot winner select. RED_ARB_RR_EN defined:
//               round-robin search from ptr; undefined: lowest index wins.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PTRW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PTRW-1:0] ptr,
    output logic [NREQ-1:0] grant
);

    logic w_found;

`ifdef RED_ARB_RR_EN
    logic [PTRW:0] w_sum;

    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        for (int off = 0; off < NREQ; off++) begin
            // ptr and off are both below NREQ, so one subtraction wraps
            w_sum = {1'b0, ptr} + (PTRW+1)'(off);
            if (w_sum >= (PTRW+1)'(NREQ))
                w_sum = w_sum - (PTRW+1)'(NREQ);
            if (!w_found && req[w_sum[PTRW-1:0]]) begin
                grant[w_sum[PTRW-1:0]] = 1'b1;
                w_found                = 1'b1;
            end
        end
    end
`else
    logic w_unused_ptr;
    assign w_unused_ptr = ^ptr;

    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req[i]) begin
                grant[i] = 1'b1;
                w_found  = 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/reduction_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reduction_arbiter
// Description : Arbitrates NREQ requesters onto one shared reduction unit and
//               returns the opcode-selected result bit over valid/ready.
//               Macro RED_ARB_RR_EN selects round-robin over fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module reduction_arbiter
    import reduction_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ*3-1:0]    req_op,
    output logic [NREQ-1:0]      gnt,
    output logic [WIDTH-1:0]     red_x,
    input  logic [5:0]           red_y,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic                 rsp_bit,
    output logic                 rsp_err,
    output logic                 busy
);

    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          r_state;
    state_t          w_state_next;
    logic [NREQ-1:0] w_pick;
    logic [PTRW-1:0] w_win_idx;
    logic [PTRW-1:0] r_win_idx;
    logic [2:0]      r_op;
    logic            w_start;

    assign w_start = (r_state == IDLE) && (|req);
    assign busy    = (r_state != IDLE);

`ifdef RED_ARB_RR_EN
    logic [PTRW-1:0] r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ptr <= '0;
        else if (w_start)
            r_ptr <= (w_win_idx == PTRW'(NREQ-1)) ? '0 : w_win_idx + 1'b1;
    end

    rr_pick #(.NREQ(NREQ), .PTRW(PTRW)) u_pick (
        .req   (req),
        .ptr   (r_ptr),
        .grant (w_pick)
    );
`else
    rr_pick #(.NREQ(NREQ), .PTRW(PTRW)) u_pick (
        .req   (req),
        .ptr   ({PTRW{1'b0}}),
        .grant (w_pick)
    );
`endif

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick[i])
                w_win_idx = PTRW'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (|req) w_state_next = EVAL;
            EVAL:    w_state_next = RESP;
            RESP:    if (rsp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            red_x     <= '0;
            r_op      <= '0;
            r_win_idx <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_bit   <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            gnt <= w_start ? w_pick : '0;
            if (w_start) begin
                red_x     <= req_data[w_win_idx*WIDTH +: WIDTH];
                r_op      <= req_op[w_win_idx*3 +: 3];
                r_win_idx <= w_win_idx;
            end
            // red_y reflects red_x registered on the previous edge
            if (r_state == EVAL) begin
                {rsp_err, rsp_bit} <= sel_result(r_op, red_y);
                rsp_id             <= IDW'(r_win_idx);
                rsp_valid          <= 1'b1;
            end else if ((r_state == RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reduction_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_reduction_arbiter
// Description : Directed self-checking bench for reduction_arbiter, with a
//               behavioural model of the shared reduction unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reduction_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] req_data = '0;
    logic [NREQ*3-1:0]     req_op = '0;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      red_x;
    logic [5:0]            red_y;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b1;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_bit;
    logic                  rsp_err;
    logic                  busy;

    int errors = 0;
    int checks = 0;

    assign red_y = {&red_x, ~&red_x, |red_x, ~|red_x, ^red_x, ~^red_x};

    always #5 clk = ~clk;

    reduction_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .req_op    (req_op),
        .gnt       (gnt),
        .red_x     (red_x),
        .red_y     (red_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_bit   (rsp_bit),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    task automatic set_req(input int r, input logic [WIDTH-1:0] d, input logic [2:0] op);
        req = '0;
        req[r] = 1'b1;
        req_data[r*WIDTH +: WIDTH] = d;
        req_op[r*3 +: 3] = op;
    endtask

    // Runs one job with rsp_ready high and returns what the DUT produced.
    task automatic do_job(input int r, input logic [WIDTH-1:0] d, input logic [2:0] op,
                          output logic [NREQ-1:0] g, output logic v, output logic [IDW-1:0] id,
                          output logic b, output logic e);
        set_req(r, d, op);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        g = gnt;
        req = '0;
        @(posedge clk); #1;
        v  = rsp_valid;
        id = rsp_id;
        b  = rsp_bit;
        e  = rsp_err;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #12;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
        checks++; if (red_x !== 4'b0000) begin errors++; $display("FAIL reset_red_x: got %b expected 0000", red_x); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d expected 0", rsp_id); end
        checks++; if ({rsp_bit, rsp_err} !== 2'b00) begin errors++; $display("FAIL reset_bit_err: got %b expected 00", {rsp_bit, rsp_err}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        set_req(0, 4'b0111, 3'd4);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b expected 0001", gnt); end
        checks++; if (red_x !== 4'b0111) begin errors++; $display("FAIL single_red_x: got %b expected 0111", red_x); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b expected 0", rsp_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
        req = '0;
        @(posedge clk); #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_gnt_clr: got %b expected 0000", gnt); end
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", rsp_valid); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL single_id: got %0d expected 0", rsp_id); end
        checks++; if (rsp_bit !== 1'b1) begin errors++; $display("FAIL single_bit: got %b expected 1", rsp_bit); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL single_err: got %b expected 0", rsp_err); end
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_valid_clr: got %b expected 0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got %b expected 0", busy); end
        @(negedge clk);
    endtask

    task automatic test_opcodes();
        logic [3:0] vd [0:9];
        logic [2:0] vo [0:9];
        logic       vb [0:9];
        logic       ve [0:9];
        logic [NREQ-1:0] g;
        logic v, b, e;
        logic [IDW-1:0] id;
        vd = '{4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b1111, 4'b1111, 4'b0101, 4'b0101};
        vo = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd4, 3'd6, 3'd7};
        vb = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        ve = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 10; i++) begin
            do_job(i % NREQ, vd[i], vo[i], g, v, id, b, e);
            checks++; if (v !== 1'b1) begin errors++; $display("FAIL op%0d_valid data=%b: got %b expected 1", vo[i], vd[i], v); end
            checks++; if (id !== IDW'(i % NREQ)) begin errors++; $display("FAIL op%0d_id: got %0d expected %0d", vo[i], id, i % NREQ); end
            checks++; if (b !== vb[i]) begin errors++; $display("FAIL op%0d_bit data=%b: got %b expected %b", vo[i], vd[i], b, vb[i]); end
            checks++; if (e !== ve[i]) begin errors++; $display("FAIL op%0d_err data=%b: got %b expected %b", vo[i], vd[i], e, ve[i]); end
        end
    endtask

    task automatic test_fairness();
        logic [NREQ-1:0] g;
        logic [NREQ-1:0] exp_g;
        logic [IDW-1:0]  id;
        int              exp_id;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req_data  = {4'b1111, 4'b1111, 4'b1111, 4'b1111};
        req_op    = '0;
        rsp_ready = 1'b1;
        req       = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            @(posedge clk); #1;
            g = gnt;
            @(posedge clk); #1;
            id = rsp_id;
            @(posedge clk); #1;
`ifdef RED_ARB_RR_EN
            exp_id = j % NREQ;
`else
            exp_id = 0;
`endif
            exp_g = '0;
            exp_g[exp_id] = 1'b1;
            checks++; if (g !== exp_g) begin errors++; $display("FAIL fair_gnt job%0d: got %b expected %b", j, g, exp_g); end
            checks++; if (id !== IDW'(exp_id)) begin errors++; $display("FAIL fair_id job%0d: got %0d expected %0d", j, id, exp_id); end
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_back_pressure();
        set_req(2, 4'b1000, 3'd2);
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL bp_gnt: got %b expected 0100", gnt); end
        req = 4'b0001;
        req_data[3:0] = 4'b0000;
        req_op[2:0]   = 3'd3;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            checks++; if ({rsp_valid, rsp_id, rsp_bit, rsp_err} !== {1'b1, 2'd2, 1'b1, 1'b0})
                begin errors++; $display("FAIL bp_hold cyc%0d: got v/id/bit/err=%b expected 11010", k, {rsp_valid, rsp_id, rsp_bit, rsp_err}); end
            checks++; if ({busy, gnt} !== 5'b10000) begin errors++; $display("FAIL bp_busy_gnt cyc%0d: got %b expected 10000", k, {busy, gnt}); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if ({rsp_valid, busy, gnt} !== 6'b000000) begin errors++; $display("FAIL bp_release: got %b expected 000000", {rsp_valid, busy, gnt}); end
        @(posedge clk); #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL bp_next_gnt: got %b expected 0001", gnt); end
        req = '0;
        @(posedge clk); #1;
        checks++; if ({rsp_id, rsp_bit} !== {2'd0, 1'b1}) begin errors++; $display("FAIL bp_next_rsp: got id/bit=%b expected 001", {rsp_id, rsp_bit}); end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_x_prop();
        logic [3:0]      xd;
        logic            exp_b;
        logic [NREQ-1:0] g;
        logic v, b, e;
        logic [IDW-1:0]  id;
        xd    = 4'bx010;
        exp_b = ^xd;
        do_job(1, xd, 3'd4, g, v, id, b, e);
        checks++; if (b !== exp_b) begin errors++; $display("FAIL x_xor: got %b expected %b", b, exp_b); end
        do_job(1, xd, 3'd2, g, v, id, b, e);
        checks++; if (b !== 1'b1) begin errors++; $display("FAIL x_or: got %b expected 1", b); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL x_or_err: got %b expected 0", e); end
    endtask

    task automatic test_reset_mid_resp();
        set_req(2, 4'b1010, 3'd4);
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        req = '0;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid: got %b expected 1", rsp_valid); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if ({rsp_valid, rsp_id, rsp_bit, rsp_err} !== 5'b00000) begin errors++; $display("FAIL rmid_rsp: got %b expected 00000", {rsp_valid, rsp_id, rsp_bit, rsp_err}); end
        checks++; if ({busy, gnt, red_x} !== 9'b0) begin errors++; $display("FAIL rmid_state: got %b expected 000000000", {busy, gnt, red_x}); end
        @(negedge clk);
        rst_n     = 1'b1;
        req_data  = {4'b0001, 4'b0001, 4'b0001, 4'b0001};
        req_op    = {3'd2, 3'd2, 3'd2, 3'd2};
        req       = 4'b1111;
        @(posedge clk); #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rmid_next_gnt: got %b expected 0001", gnt); end
        req       = '0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if ({rsp_valid, rsp_id} !== 3'b100) begin errors++; $display("FAIL rmid_next_rsp: got %b expected 100", {rsp_valid, rsp_id}); end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_opcodes();
        test_fairness();
        test_back_pressure();
        test_x_prop();
        test_reset_mid_resp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/reduction_arbiter.md
Name: reduction_arbiter

Overview:
- Shares one combinational reduction unit between NREQ requesters. The unit takes a WIDTH-bit x and returns y[5:0] = {&x, ~&x, |x, ~|x, ^x, ~^x}.
- Per job: arbitrates, registers the winning operand onto the unit, selects the requested result bit by opcode, and returns it over a valid/ready response channel tagged with the requester id.
- Sits between client blocks and the shared reduction datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 4, operand width driven to the reduction unit.
- IDW, 2, response id width (>= clog2(NREQ)).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester request level; held until its gnt bit is seen.
- req_data  input  NREQ*WIDTH  operands; requester i uses slice [i*WIDTH +: WIDTH].
- req_op  input  NREQ*3  opcodes; requester i uses slice [i*3 +: 3].
- gnt  output  NREQ  one-hot accept pulse, one cycle.
- red_x  output  WIDTH  registered operand to the shared reduction unit.
- red_y  input  6  reduction unit result {and,nand,or,nor,xor,xnor}.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  IDW  index of the granted requester.
- rsp_bit  output  1  selected reduction result.
- rsp_err  output  1  illegal opcode flag.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; gnt=0, red_x=0, rsp_valid=0, rsp_id=0, rsp_bit=0, rsp_err=0; round-robin pointer=0.
- Reset mid-operation aborts the job. Any pending response is dropped and not replayed.
- Opcode encoding:
  - 0 AND → red_y[5]
  - 1 NAND → red_y[4]
  - 2 OR → red_y[3]
  - 3 NOR → red_y[2]
  - 4 XOR → red_y[1]
  - 5 XNOR → red_y[0]
  - 6, 7 illegal → rsp_bit=0, rsp_err=1.
- FSM IDLE → EVAL → RESP → IDLE:
  - IDLE, edge with req != 0: pick winner w. Load red_x from w's operand and the internal op register from w's opcode. Set gnt = 1<<w for the next cycle only. Go to EVAL. If req == 0, stay in IDLE.
  - EVAL, next edge: sample red_y. Load rsp_bit and rsp_err, set rsp_id=w and rsp_valid=1, clear gnt. Go to RESP.
  - RESP, edge with rsp_ready=1: clear rsp_valid, go to IDLE. With rsp_ready=0, hold all rsp_* outputs stable.
- Latency: req sampled at edge E0 → gnt high E0..E1 → rsp_valid high from E1. Minimum 3 cycles per job.
- Requests arriving or changing while busy are ignored until the next IDLE.
- Round-robin: priority search starts at the pointer. On every grant, pointer ← (w+1) mod NREQ, wrapping NREQ-1 → 0.
- A requester must not change req_data/req_op while req=1 and gnt has not yet been seen.
- X/Z bits on red_y pass through to rsp_bit unchanged. No masking.

Optional Feature:
- Macro: RED_ARB_RR_EN.
- Defined: round-robin arbitration as above.
- Undefined: fixed priority, lowest index wins. Pointer logic is removed and everything else is unchanged. Starvation of high indices is accepted.

Decomposition:
- Shared package/include holds:
  - opcode localparams OP_AND..OP_XNOR
  - result-bit index constants for red_y
  - FSM state encodings IDLE/EVAL/RESP
- One sub-module: rr_pick. Inputs req vector and pointer; output one-hot winner. Purely combinational, with a fixed-priority variant under the macro.
- The reduction unit itself is instantiated outside this block.

Test Plan:
- Single job: req[0]=1, data 4'b0111, op 4 (XOR) → gnt=0001 one cycle; rsp_valid two edges after request; rsp_id=0, rsp_bit=1, rsp_err=0.
- Opcode sweep on 4'b0101 and 4'b1111:
  - 0101: AND=0, NAND=1, OR=1, NOR=0, XOR=0, XNOR=1.
  - 1111: AND=1, XOR=0.
  - op 6 → rsp_bit=0, rsp_err=1.
- Fairness: all four req held high → grant order 0, 1, 2, 3, 0 (macro on); macro off → 0 every job.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_* stable, busy=1, no new gnt; rsp_ready=1 → return to IDLE, next grant follows.
- X propagation: data 4'bx010, op 4 → rsp_bit=x; op 2 (OR) → rsp_bit=1.
- Reset mid-RESP: rst_n low with rsp_valid=1 → outputs zero immediately; after release the next grant goes to requester 0.
